// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forward-select codes
// and the EX/MEM tracking entry.
package hazard_forward_ctrl_pkg;

    localparam int TRK_RD_W = 5;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_OP1  = 2'b01;
    localparam logic [1:0] FWD_OP2  = 2'b10;
    localparam logic [1:0] FWD_BOTH = 2'b11;

    typedef struct packed {
        logic                valid;
        logic [TRK_RD_W-1:0] rd;
        logic                reg_write;
        logic                mem_read;
    } track_t;

    localparam track_t TRK_BUBBLE = '0;

endpackage

// File: rtl/hazard_forward_ctrl_match.sv
// Combinational producer/consumer comparator: one tracking entry against
// both ID source registers; x0 never matches.
module hazard_match
    import hazard_forward_ctrl_pkg::*;
(
    input  track_t              i_entry,
    input  logic [TRK_RD_W-1:0] i_rs1,
    input  logic [TRK_RD_W-1:0] i_rs2,
    output logic [1:0]          o_mask
);

    logic w_live;
    logic w_hit1;
    logic w_hit2;

    assign w_live = i_entry.valid & i_entry.reg_write;
    assign w_hit1 = w_live && (i_entry.rd == i_rs1) && (i_rs1 != '0);
    assign w_hit2 = w_live && (i_entry.rd == i_rs2) && (i_rs2 != '0);

    // Build the 2-bit mask in the forward-select encoding.
    always_comb begin
        o_mask = FWD_NONE;
        if (w_hit1) o_mask = o_mask | FWD_OP1;
        if (w_hit2) o_mask = o_mask | FWD_OP2;
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard controller: tracks EX/MEM producers, drives forward selects,
// load-use / distance-2 stalls and branch flush. Option macro: FWD_MEM_EN.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = TRK_RD_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   ID_Valid,
    input  logic [REG_ADDR_W-1:0]  ID_Rs1,
    input  logic [REG_ADDR_W-1:0]  ID_Rs2,
    input  logic [REG_ADDR_W-1:0]  ID_Rd,
    input  logic                   ID_Reg_Write,
    input  logic                   ID_Mem_Read,
    input  logic                   Branch_Taken,
    output logic [1:0]             Signal_Forward,
`ifdef FWD_MEM_EN
    output logic [1:0]             Signal_Forward_Mem,
`endif
    output logic                   Stall,
    output logic                   Flush,
    output logic [STALL_CNT_W-1:0] Stall_Count
);

    track_t r_ex_t;
    track_t r_mem_t;
    track_t w_id_entry;

    logic [1:0] r_fwd;
    logic [1:0] w_m1;
    logic [1:0] w_m2;
    logic [1:0] w_m2_only;
    logic       w_load_use;
    logic       w_dist2_stall;
    logic       w_stall;
    logic       w_enter;

    logic [STALL_CNT_W-1:0] r_stall_count;

    hazard_match u_match_ex (
        .i_entry (r_ex_t),
        .i_rs1   (ID_Rs1),
        .i_rs2   (ID_Rs2),
        .o_mask  (w_m1)
    );

    hazard_match u_match_mem (
        .i_entry (r_mem_t),
        .i_rs1   (ID_Rs1),
        .i_rs2   (ID_Rs2),
        .o_mask  (w_m2)
    );

    // Distance-1 wins per operand, so MEM only counts where EX missed.
    assign w_m2_only  = w_m2 & ~w_m1;
    assign w_load_use = (|w_m1) & r_ex_t.mem_read;

`ifdef FWD_MEM_EN
    assign w_dist2_stall = 1'b0;
`else
    assign w_dist2_stall = |w_m2_only;
`endif

    assign w_stall = ID_Valid & ~Branch_Taken & (w_load_use | w_dist2_stall);
    assign w_enter = ID_Valid & ~Branch_Taken & ~w_stall;

    assign Stall          = w_stall;
    assign Flush          = Branch_Taken;
    assign Signal_Forward = r_fwd;
    assign Stall_Count    = r_stall_count;

    assign w_id_entry = '{
        valid:     1'b1,
        rd:        ID_Rd,
        reg_write: ID_Reg_Write,
        mem_read:  ID_Mem_Read
    };

    // Advance the EX/MEM tracking pipeline; stalls, flushes and idle ID insert a bubble.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ex_t  <= TRK_BUBBLE;
            r_mem_t <= TRK_BUBBLE;
        end else begin
            r_mem_t <= r_ex_t;
            r_ex_t  <= w_enter ? w_id_entry : TRK_BUBBLE;
        end
    end

    // Register the ALU-result forward select for the instruction entering EX.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_fwd <= FWD_NONE;
        else       r_fwd <= w_enter ? w_m1 : FWD_NONE;
    end

`ifdef FWD_MEM_EN
    logic [1:0] r_fwd_mem;

    assign Signal_Forward_Mem = r_fwd_mem;

    // Register the MEM/WB forward select for the instruction entering EX.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_fwd_mem <= FWD_NONE;
        else       r_fwd_mem <= w_enter ? w_m2_only : FWD_NONE;
    end
`endif

    // Saturating count of stall cycles.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_stall_count <= '0;
        else if (w_stall && !(&r_stall_count))
            r_stall_count <= r_stall_count + 1'b1;
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench for hazard_forward_ctrl: instruction-stream model,
// directed hazard cases, random traffic, async reset mid-stall.
module tb_hazard_forward_ctrl;

`ifdef FWD_MEM_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        bit       v;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit [4:0] rd;
        bit       rw;
        bit       mr;
    } ins_t;

    typedef struct {
        bit       st;
        bit       fl;
        bit [1:0] f;
        bit [1:0] fm;
        int       c16;
        int       c3;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ID_Valid;
    logic [4:0]  ID_Rs1;
    logic [4:0]  ID_Rs2;
    logic [4:0]  ID_Rd;
    logic        ID_Reg_Write;
    logic        ID_Mem_Read;
    logic        Branch_Taken;
    logic [1:0]  Signal_Forward;
    logic [1:0]  Signal_Forward_Mem;
    logic        Stall;
    logic        Flush;
    logic [15:0] Stall_Count;
    logic [1:0]  sf_small;
    logic [1:0]  sfm_small;
    logic        stall_small;
    logic        flush_small;
    logic [2:0]  cnt_small;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    ins_t pipe[$];
    bit [1:0] cur_f;
    bit [1:0] cur_fm;
    int cnt;

    always #5 Clk = ~Clk;

    hazard_forward_ctrl dut (
        .Clk                (Clk),
        .Reset              (Reset),
        .ID_Valid           (ID_Valid),
        .ID_Rs1             (ID_Rs1),
        .ID_Rs2             (ID_Rs2),
        .ID_Rd              (ID_Rd),
        .ID_Reg_Write       (ID_Reg_Write),
        .ID_Mem_Read        (ID_Mem_Read),
        .Branch_Taken       (Branch_Taken),
        .Signal_Forward     (Signal_Forward),
`ifdef FWD_MEM_EN
        .Signal_Forward_Mem (Signal_Forward_Mem),
`endif
        .Stall              (Stall),
        .Flush              (Flush),
        .Stall_Count        (Stall_Count)
    );

    hazard_forward_ctrl #(.STALL_CNT_W(3)) dut_small (
        .Clk                (Clk),
        .Reset              (Reset),
        .ID_Valid           (ID_Valid),
        .ID_Rs1             (ID_Rs1),
        .ID_Rs2             (ID_Rs2),
        .ID_Rd              (ID_Rd),
        .ID_Reg_Write       (ID_Reg_Write),
        .ID_Mem_Read        (ID_Mem_Read),
        .Branch_Taken       (Branch_Taken),
        .Signal_Forward     (sf_small),
`ifdef FWD_MEM_EN
        .Signal_Forward_Mem (sfm_small),
`endif
        .Stall              (stall_small),
        .Flush              (flush_small),
        .Stall_Count        (cnt_small)
    );

`ifndef FWD_MEM_EN
    assign Signal_Forward_Mem = 2'b00;
    assign sfm_small = 2'b00;
`endif

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    function automatic bit hits(input ins_t p, input bit [4:0] rs);
        return p.v && p.rw && (p.rd == rs) && (rs != 5'd0);
    endfunction

    function automatic ins_t mk(input bit v, input int rs1, input int rs2,
                                input int rd, input bit rw, input bit mr);
        ins_t x;
        x.v = v;
        x.rs1 = 5'(rs1);
        x.rs2 = 5'(rs2);
        x.rd = 5'(rd);
        x.rw = rw;
        x.mr = mr;
        return x;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        ins_t b;
        b = mk(0, 0, 0, 0, 0, 0);
        pipe.delete();
        pipe.push_back(b);
        pipe.push_back(b);
        cur_f = 2'b00;
        cur_fm = 2'b00;
        cnt = 0;
    endtask

    // Drive one cycle at posedge+1; push expected observation for this cycle.
    task automatic step(input ins_t x, input bit bt, output bit st);
        bit [1:0] d1;
        bit [1:0] d2;
        bit [4:0] rs;
        bit lu;
        bit enter;
        exp_t e;
        ins_t b;
        ID_Valid = x.v;
        ID_Rs1 = x.rs1;
        ID_Rs2 = x.rs2;
        ID_Rd = x.rd;
        ID_Reg_Write = x.rw;
        ID_Mem_Read = x.mr;
        Branch_Taken = bt;
        d1 = 2'b00;
        d2 = 2'b00;
        for (int op = 0; op < 2; op++) begin
            rs = (op == 0) ? x.rs1 : x.rs2;
            if (hits(pipe[0], rs)) d1[op] = 1'b1;
            else if (hits(pipe[1], rs)) d2[op] = 1'b1;
        end
        lu = x.v && (d1 != 2'b00) && pipe[0].mr;
        st = x.v && !bt && (lu || (!FWD && d2 != 2'b00));
        e.st = st;
        e.fl = bt;
        e.f = cur_f;
        e.fm = cur_fm;
        e.c16 = sat(cnt, 65535);
        e.c3 = sat(cnt, 7);
        sb.push_back(e);
        if (st) cnt++;
        enter = x.v && !st && !bt;
        cur_f = enter ? d1 : 2'b00;
        cur_fm = (enter && FWD) ? d2 : 2'b00;
        b = mk(0, 0, 0, 0, 0, 0);
        void'(pipe.pop_back());
        pipe.push_front(enter ? x : b);
        @(posedge Clk);
        #1;
    endtask

    // Issue one instruction, holding it while the model says stall.
    task automatic issue(input ins_t x, input bit bt);
        bit st;
        int n;
        step(x, bt, st);
        n = 0;
        while (st && n < 4) begin
            step(x, 1'b0, st);
            n++;
        end
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(mk(0, 0, 0, 0, 0, 0), 1'b0);
    endtask

    // Monitor: every negedge, compare DUT outputs against the next expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stall", Stall, e.st);
                chk("flush", Flush, e.fl);
                chk("fwd", Signal_Forward, e.f);
                if (FWD) chk("fwd_mem", Signal_Forward_Mem, e.fm);
                chk("stall_count", Stall_Count, e.c16);
                chk("stall_count_sat3", cnt_small, e.c3);
                chk("small_stall", stall_small, e.st);
            end
        end
    end

    initial begin
        bit st;
        ins_t x;
        Reset = 1'b1;
        ID_Valid = 1'b0;
        ID_Rs1 = '0;
        ID_Rs2 = '0;
        ID_Rd = '0;
        ID_Reg_Write = 1'b0;
        ID_Mem_Read = 1'b0;
        Branch_Taken = 1'b0;
        model_reset();
        @(posedge Clk);
        @(posedge Clk);
        #1;
        chk("reset_fwd", Signal_Forward, 0);
        chk("reset_fwd_mem", Signal_Forward_Mem, 0);
        chk("reset_stall", Stall, 0);
        chk("reset_flush", Flush, 0);
        chk("reset_count", Stall_Count, 0);
        Reset = 1'b0;

        // ADD x5 ; SUB x?,x5,x6 -> fwd 01
        issue(mk(1, 1, 2, 5, 1, 0), 1'b0);
        issue(mk(1, 5, 6, 8, 1, 0), 1'b0);
        nops(3);
        // ADD x5 ; ADD x7,x5,x5 -> fwd 11
        issue(mk(1, 1, 2, 5, 1, 0), 1'b0);
        issue(mk(1, 5, 5, 7, 1, 0), 1'b0);
        nops(3);
        // LW x3 ; ADD using x3 -> load-use
        issue(mk(1, 1, 0, 3, 1, 1), 1'b0);
        issue(mk(1, 3, 4, 9, 1, 0), 1'b0);
        nops(3);
        // writer to x0 then reader of x0
        issue(mk(1, 1, 2, 0, 1, 0), 1'b0);
        issue(mk(1, 0, 0, 6, 1, 0), 1'b0);
        nops(3);
        // distance-2 dependency on operand 2
        issue(mk(1, 1, 2, 4, 1, 0), 1'b0);
        issue(mk(1, 1, 2, 10, 1, 0), 1'b0);
        issue(mk(1, 7, 4, 11, 1, 0), 1'b0);
        nops(3);
        // load-use coinciding with taken branch
        issue(mk(1, 1, 0, 3, 1, 1), 1'b0);
        issue(mk(1, 3, 0, 9, 1, 0), 1'b1);
        nops(3);
        // repeated load-use to push the 3-bit counter into saturation
        for (int i = 0; i < 6; i++) begin
            issue(mk(1, 1, 0, 2, 1, 1), 1'b0);
            issue(mk(1, 2, 2, 12, 1, 0), 1'b0);
        end
        nops(3);

        // Async reset while a load-use stall is showing
        issue(mk(1, 1, 0, 3, 1, 1), 1'b0);
        step(mk(1, 3, 4, 9, 1, 0), 1'b0, st);
        chk("midstall_setup", st, 1);
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        chk("rst_async_stall", Stall, 0);
        chk("rst_async_fwd", Signal_Forward, 0);
        chk("rst_async_fwd_mem", Signal_Forward_Mem, 0);
        chk("rst_async_count", Stall_Count, 0);
        chk("rst_async_count3", cnt_small, 0);
        model_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Random traffic over a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            x = mk($urandom_range(0, 99) < 85,
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 9) < 7,
                   $urandom_range(0, 9) < 3);
            issue(x, $urandom_range(0, 99) < 8);
        end
        nops(3);

        @(negedge Clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Pipeline hazard controller for the 5-stage 8-bit RISC-V core. It tracks the destination register and type of the instructions in EX and MEM, and compares them against the source registers of the instruction in ID. From that comparison it drives the forward-select code consumed by the EX-stage operand forwarding unit, and it issues load-use / distance-2 stalls and branch flushes. Sits beside the ID/EX pipeline register; owns no datapath.

## Interface
- REG_ADDR_W, 5, register index width
- STALL_CNT_W, 16, stall statistics counter width

- Clk  in  1  core clock, all state on rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- ID_Valid  in  1  ID holds a real instruction
- ID_Rs1  in  REG_ADDR_W  ID source 1 index
- ID_Rs2  in  REG_ADDR_W  ID source 2 index
- ID_Rd  in  REG_ADDR_W  ID destination index
- ID_Reg_Write  in  1  ID instruction writes Rd
- ID_Mem_Read  in  1  ID instruction is a load
- Branch_Taken  in  1  EX resolved a taken branch/jump this cycle
- Signal_Forward  out  2  registered; bit0 = operand 1 from ALU result, bit1 = operand 2 from ALU result (00 none, 01, 10, 11 both)
- Signal_Forward_Mem  out  2  registered; same encoding, source = MEM/WB write-back data (present only with FWD_MEM_EN)
- Stall  out  1  combinational; hold PC and IF/ID, bubble into EX
- Flush  out  1  combinational; squash IF/ID and EX entry
- Stall_Count  out  STALL_CNT_W  saturating count of Stall cycles

## Operation
- Internal tracking registers EX_T and MEM_T, each {valid, rd, reg_write, mem_read}. Each cycle: MEM_T <= EX_T; EX_T <= ID entry or bubble (valid=0).
- A producer P "matches" source rs iff P.valid & P.reg_write & P.rd == rs & rs != 0. x0 never matches.
- Distance-1 hazard (EX_T matches ID rs):
  - EX_T.mem_read=0: next Signal_Forward bit set.
  - EX_T.mem_read=1 (load-use): Stall=1, bubble into EX_T.
- Distance-2 hazard (MEM_T matches ID rs, no distance-1 match on same rs): handled per Configuration. Distance-1 match has priority over distance-2 per operand.
- Distance 3+: none; register file is write-before-read.
- Stall=1: ID inputs are held by upstream; EX_T loads bubble; Signal_Forward/Signal_Forward_Mem load 00.
- Branch_Taken=1: Flush=1, Stall forced 0, EX_T loads bubble, forward outputs load 00. Branch_Taken overrides Stall.
- ID_Valid=0: treated as bubble; Stall=0.
- Stall_Count increments on each cycle with Stall=1, holds at all-ones.

## Timing
- Reset values: Signal_Forward=00, Signal_Forward_Mem=00, Stall_Count=0, EX_T/MEM_T valid=0; Stall=0 and Flush=0 follow from cleared state with no inputs asserted.
- Forward selects: computed from ID vs tracking state, registered at the edge where the instruction enters EX; valid for exactly its EX cycle.
- Stall/Flush: same-cycle combinational from inputs and tracking registers.
- Load-use costs 1 stall cycle with FWD_MEM_EN, 2 without.
- Reset mid-stall: all tracking cleared immediately; Stall deasserts with no clock required.

## Configuration
- FWD_MEM_EN defined: distance-2 matches set the corresponding Signal_Forward_Mem bit (no stall); a stalled load-use resolves after 1 cycle by forwarding from MEM/WB.
- FWD_MEM_EN undefined: Signal_Forward_Mem port absent; any distance-2 match asserts Stall for 1 cycle (then distance 3, no action).

## Structure
- Shared package: the 2-bit forward-select encodings (FWD_NONE, FWD_OP1, FWD_OP2, FWD_BOTH) and the tracking-entry struct {valid, rd, reg_write, mem_read}.
- One sub-module: hazard_match, a combinational comparator taking one tracking entry plus Rs1/Rs2 and returning the 2-bit match mask; instantiated for EX_T and MEM_T.

## Test plan
- ADD x5 then SUB using x5,x6 -> Signal_Forward=01 in SUB's EX cycle, Stall=0.
- ADD x5 then ADD x7,x5,x5 -> Signal_Forward=11.
- LW x3 then ADD using x3 -> Stall=1 for 1 cycle, Signal_Forward=00, Signal_Forward_Mem=01 with FWD_MEM_EN; without it Stall=1 for 2 cycles and Stall_Count=2.
- Writer to x0 followed by a reader of x0 -> no forward, no stall.
- Load-use stall coinciding with Branch_Taken=1 -> Flush=1, Stall=0, EX_T bubble, Stall_Count unchanged.
- Reset asserted mid-stall -> Stall=0 asynchronously, all outputs at reset values; Stall_Count saturation at 0xFFFF holds under a continuous stall.
